bf8b_mem: RTL and testbench

Memory-side responder for the 8-bit bus driven by the CPU memory interface: a 256-byte address space holding program, data tape and a small memory-mapped I/O window. It decodes the CPU's address/write-enable, returns registered read data one cycle after the address is presented, and bridges bytes between the CPU and two valid/ready byte streams (console out, console in). A separate load port fills RAM while the CPU is held in reset.

---
 rtl/bf8b_mem_if.sv | 28 ++
 rtl/bf8b_mem.sv | 154 +++++++++++++++
 tb/tb_bf8b_mem.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bf8b_mem_if.sv
// rtl/bf8b_mem_if.sv - CPU bus, boot-load port and console byte streams of bf8b_mem
interface bf8b_mem_if;
    logic [7:0] cpu_addr;
    logic       cpu_we;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       load_we;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output cpu_addr, cpu_we, cpu_wdata, load_we, load_addr, load_data,
        output tx_ready, rx_data, rx_valid,
        input  cpu_rdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  cpu_addr, cpu_we, cpu_wdata, load_we, load_addr, load_data,
        input  tx_ready, rx_data, rx_valid,
        output cpu_rdata, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/bf8b_mem.sv
// rtl/bf8b_mem.sv - 256-byte memory responder with MMIO console TX/RX byte FIFOs
module bf8b_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is dropped even when a pop happens the same cycle.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

module bf8b_mem #(
    parameter logic [7:0] MMIO_BASE = 8'hFD,
    parameter int         TX_DEPTH  = 4,
    parameter int         RX_DEPTH  = 4
) (
    input logic       clk,
    input logic       rst,
    bf8b_mem_if.slave bus
);
    localparam logic [7:0] ADDR_STATUS = MMIO_BASE;
    localparam logic [7:0] ADDR_RX     = MMIO_BASE + 8'd1;
    localparam logic [7:0] ADDR_TX     = MMIO_BASE + 8'd2;

    logic [7:0] ram_q [256];
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic       tx_ovf_q, tx_ovf_d;

    logic       is_status, is_rx, is_tx, is_ram;
    logic       cpu_wr, load_wr;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_head, rx_head;
    logic       tx_full, tx_empty, rx_full, rx_empty;

    assign is_status = (bus.cpu_addr == ADDR_STATUS);
    assign is_rx     = (bus.cpu_addr == ADDR_RX);
    assign is_tx     = (bus.cpu_addr == ADDR_TX);
    assign is_ram    = !(is_status || is_rx || is_tx);

    // The boot loader owns the cycle: a colliding CPU write loses all its effects.
    assign cpu_wr  = bus.cpu_we && !bus.load_we;
    assign load_wr = bus.load_we && (bus.load_addr < MMIO_BASE);

    assign tx_push = cpu_wr && is_tx;
    assign tx_pop  = bus.tx_valid && bus.tx_ready;
    assign rx_push = bus.rx_valid && bus.rx_ready;
    assign rx_pop  = cpu_wr && is_rx;

    bf8b_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tx_push),
        .push_data_i (bus.cpu_wdata),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    bf8b_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rx_push),
        .push_data_i (bus.rx_data),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    assign bus.tx_valid  = !tx_empty;
    assign bus.tx_data   = tx_empty ? 8'h00 : tx_head;
    assign bus.rx_ready  = !rx_full;
    assign bus.cpu_rdata = cpu_rdata_q;

    always_comb begin
        cpu_rdata_d = ram_q[bus.cpu_addr];
        if (is_status)  cpu_rdata_d = {5'b0, tx_ovf_q, tx_full, !rx_empty};
        else if (is_rx) cpu_rdata_d = rx_empty ? 8'h00 : rx_head;
        else if (is_tx) cpu_rdata_d = 8'h00;
    end

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        if (cpu_wr && is_status) tx_ovf_d = 1'b0;
        if (tx_push && tx_full)  tx_ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= 8'h00;
            tx_ovf_q    <= 1'b0;
        end else begin
            cpu_rdata_q <= cpu_rdata_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

    // Loading must work while the CPU sits in reset; only CPU writes honour rst.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            ram_q[bus.load_addr] <= bus.load_data;
        end else if (!rst && cpu_wr && is_ram) begin
            ram_q[bus.cpu_addr] <= bus.cpu_wdata;
        end
    end
endmodule

// File: tb/tb_bf8b_mem.sv
// tb/tb_bf8b_mem.sv - scoreboard bench for bf8b_mem
module tb_bf8b_mem;
    localparam logic [7:0] A_ST = 8'hFD;
    localparam logic [7:0] A_RX = 8'hFE;
    localparam logic [7:0] A_TX = 8'hFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bf8b_mem_if bus();

    bf8b_mem #(.MMIO_BASE(8'hFD), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] txq [$];
    logic [7:0] rxm [$];
    logic [7:0] rdq [$];
    bit         ovf_m = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status_exp();
        return {5'b0, ovf_m, (txq.size() == 4), (rxm.size() != 0)};
    endfunction

    function automatic logic [7:0] rx_exp();
        return (rxm.size() != 0) ? rxm[0] : 8'h00;
    endfunction

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
        @(posedge clk); #2;
        bus.cpu_addr = a;
        rdq.push_back(e);
        @(posedge clk); #1;
        check(tag, bus.cpu_rdata, rdq.pop_front());
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] junk;
        @(posedge clk); #2;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        if (a == A_TX) begin
            if (txq.size() < 4) txq.push_back(d);
            else ovf_m = 1'b1;
        end else if (a == A_ST) begin
            ovf_m = 1'b0;
        end else if (a == A_RX && rxm.size() != 0) begin
            junk = rxm.pop_front();
        end
        @(posedge clk); #1;
        bus.cpu_we = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(posedge clk); #1;
        bus.load_we = 1'b0;
    endtask

    task automatic collide(input logic [7:0] ca, input logic [7:0] cd,
                           input logic [7:0] la, input logic [7:0] ld);
        @(posedge clk); #2;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.cpu_we    = 1'b1;
        bus.load_we   = 1'b1;
        bus.load_addr = la;
        bus.load_data = ld;
        @(posedge clk); #1;
        bus.cpu_we  = 1'b0;
        bus.load_we = 1'b0;
    endtask

    task automatic rx_step(input bit push, input logic [7:0] d, input bit pop);
        bit         acc;
        logic [7:0] junk;
        @(posedge clk); #2;
        acc          = push && (rxm.size() < 4);
        bus.rx_valid = push;
        bus.rx_data  = d;
        if (pop) begin
            bus.cpu_addr = A_RX;
            bus.cpu_we   = 1'b1;
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.cpu_we   = 1'b0;
        if (pop && rxm.size() != 0) junk = rxm.pop_front();
        if (acc) rxm.push_back(d);
        check("rx_ready", {7'b0, bus.rx_ready}, {7'b0, (rxm.size() < 4)});
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (txq.size() == 0) check("tx_spurious", {7'b0, bus.tx_valid}, 8'h00);
            else check("tx_data", bus.tx_data, txq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cpu_addr  = 8'h00;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 8'h00;
        bus.load_we   = 1'b0;
        bus.load_addr = 8'h00;
        bus.load_data = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;

        @(posedge clk); #1;
        check("rst_rdata", bus.cpu_rdata, 8'h00);
        check("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);

        load(8'h10, 8'hA5);
        load(8'h30, 8'h5A);
        load(A_RX, 8'h11);
        @(posedge clk); #2;
        rst = 1'b0;

        rd("ram_load", 8'h10, 8'hA5);
        rd("status_idle", A_ST, status_exp());
        rd("rx_idle", A_RX, 8'h00);

        wr(8'h20, 8'h3C);
        rd("ram_wr", 8'h20, 8'h3C);
        wr(8'h30, 8'h12);
        check("read_before_write", bus.cpu_rdata, 8'h5A);
        rd("ram_new", 8'h30, 8'h12);

        collide(8'h20, 8'h55, 8'h20, 8'h77);
        rd("load_wins", 8'h20, 8'h77);
        collide(A_TX, 8'h99, A_TX, 8'h88);
        rd("collide_mmio_status", A_ST, status_exp());
        check("collide_tx_valid", {7'b0, bus.tx_valid}, 8'h00);

        for (int i = 0; i < 5; i++) wr(A_TX, 8'h41 + 8'(i));
        rd("status_full_ovf", A_ST, status_exp());
        @(posedge clk); #2;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 30 && txq.size() != 0; i++) @(posedge clk);
        check("tx_drained", 8'(txq.size()), 8'h00);
        @(posedge clk); #1;
        check("tx_valid_empty", {7'b0, bus.tx_valid}, 8'h00);
        bus.tx_ready = 1'b0;
        rd("status_ovf_sticky", A_ST, status_exp());
        wr(A_ST, 8'hFF);
        rd("status_cleared", A_ST, status_exp());

        rx_step(1'b1, 8'h61, 1'b0);
        rd("status_rx", A_ST, status_exp());
        rd("rx_head", A_RX, rx_exp());
        wr(A_RX, 8'h00);
        rd("status_rx_pop", A_ST, status_exp());
        rd("rx_empty", A_RX, rx_exp());

        for (int i = 0; i < 4; i++) rx_step(1'b1, 8'h71 + 8'(i), 1'b0);
        rx_step(1'b0, 8'h00, 1'b1);
        rx_step(1'b1, 8'h75, 1'b1);
        rx_step(1'b1, 8'h76, 1'b0);
        rx_step(1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rd("rx_order", A_RX, rx_exp());
            wr(A_RX, 8'h00);
        end
        rd("rx_drained", A_RX, rx_exp());

        wr(A_TX, 8'hB1);
        wr(A_TX, 8'hB2);
        check("tx_valid_loaded", {7'b0, bus.tx_valid}, 8'h01);
        @(posedge clk); #2;
        rst           = 1'b1;
        bus.cpu_addr  = A_TX;
        bus.cpu_wdata = 8'hC3;
        bus.cpu_we    = 1'b1;
        @(posedge clk); #1;
        bus.cpu_we = 1'b0;
        txq.delete();
        ovf_m = 1'b0;
        check("midrst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        check("midrst_rdata", bus.cpu_rdata, 8'h00);
        check("midrst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
        @(posedge clk); #2;
        rst = 1'b0;
        rd("ram_retained", 8'h10, 8'hA5);
        rd("status_after_rst", A_ST, status_exp());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
